// File: rtl/histo_run_length.sv
// Run-length histogram: counts completed data_valid runs per length, with a registered bin read port.
// Define HISTO_SATURATE_EN to make bins hold at their maximum instead of wrapping.
module histo_run_length #(
   parameter int MAX_SEQ_SIZE  = 16,
   parameter int HISTO_BIN_MAX = 1024
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             data_in,
   input  logic                             data_valid,
   input  logic                             hist_int,
   input  logic [$clog2(MAX_SEQ_SIZE)-1:0]  addr,
   output logic [$clog2(HISTO_BIN_MAX)-1:0] hist_data
);

   localparam int AW = $clog2(MAX_SEQ_SIZE);
   localparam int CW = $clog2(HISTO_BIN_MAX);
   localparam int RW = $clog2(MAX_SEQ_SIZE + 1);

   localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_SEQ_SIZE);
   localparam logic [AW-1:0] LAST_BIN = AW'(MAX_SEQ_SIZE - 1);
   localparam logic [CW-1:0] BIN_MAX  = CW'(HISTO_BIN_MAX - 1);

   logic [RW-1:0] run_q, run_d;
   logic          prev_valid_q, prev_valid_d;
   logic [CW-1:0] hist_data_q, hist_data_d;
   logic [CW-1:0] bin_q [MAX_SEQ_SIZE];
   logic [CW-1:0] bin_d [MAX_SEQ_SIZE];

   logic          commit;
   logic [AW-1:0] bin_idx;

   // The payload bit is sampled by the interface but plays no part in the histogram.
   logic unused_data_in;
   assign unused_data_in = data_in;

   always_comb begin
      commit  = 1'b0;
      bin_idx = '0;
      run_d   = run_q;

      commit  = (run_q != '0) && (hist_int || (prev_valid_q && !data_valid));
      bin_idx = (run_q >= RUN_MAX) ? LAST_BIN : run_q[AW-1:0];

      // A sequence start restarts the count; a valid cycle coincident with it opens the new run.
      if (hist_int || commit) begin
         run_d = data_valid ? RW'(1) : '0;
      end else if (data_valid && (run_q < RUN_MAX)) begin
         run_d = run_q + RW'(1);
      end

      prev_valid_d = data_valid;
      hist_data_d  = bin_q[addr];
   end

   always_comb begin
      for (int i = 0; i < MAX_SEQ_SIZE; i++) begin
         bin_d[i] = bin_q[i];
         if (commit && (bin_idx == AW'(i))) begin
`ifdef HISTO_SATURATE_EN
            if (bin_q[i] != BIN_MAX) begin
               bin_d[i] = bin_q[i] + CW'(1);
            end
`else
            bin_d[i] = bin_q[i] + CW'(1);
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q        <= '0;
         prev_valid_q <= 1'b0;
         hist_data_q  <= '0;
         for (int i = 0; i < MAX_SEQ_SIZE; i++) begin
            bin_q[i] <= '0;
         end
      end else begin
         run_q        <= run_d;
         prev_valid_q <= prev_valid_d;
         hist_data_q  <= hist_data_d;
         for (int i = 0; i < MAX_SEQ_SIZE; i++) begin
            bin_q[i] <= bin_d[i];
         end
      end
   end

   assign hist_data = hist_data_q;

endmodule

// File: tb/tb_histo_run_length.sv
// Directed bench for histo_run_length: bins tracked by hand-updated expected counts.
module tb_histo_run_length;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       data_in = 1'b0;
   logic       data_valid = 1'b0;
   logic       hist_int = 1'b0;
   logic [3:0] addr = 4'd0;
   logic [9:0] hist_data;

   int total = 0;
   int bad = 0;
   logic [9:0] exp_bin [16];

   histo_run_length dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .hist_int   (hist_int),
      .addr       (addr),
      .hist_data  (hist_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end else begin
         $display("ok   %s got=%0d", tag, got);
      end
   endtask

   task automatic read_bin(input string phase, input int a);
      addr = 4'(a);
      step();
      check_val($sformatf("%s_bin%0d", phase, a), hist_data, exp_bin[a]);
   endtask

   task automatic read_all(input string phase);
      for (int a = 0; a < 16; a++) read_bin(phase, a);
   endtask

   // bit i of pat drives data_valid in cycle i, after a one-cycle hist_int pulse
   task automatic run_pattern(input logic [15:0] pat);
      hist_int = 1'b1;
      data_valid = 1'b0;
      step();
      hist_int = 1'b0;
      for (int i = 0; i < 16; i++) begin
         data_valid = pat[i];
         data_in = ~data_in;
         step();
      end
      data_valid = 1'b0;
      step();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) exp_bin[i] = '0;

      rst_n = 1'b0;
      repeat (3) step();
      check_val("reset_hist_data", hist_data, 10'd0);
      rst_n = 1'b1;
      read_all("reset");

      // run lengths 2,3,1,8,2
      run_pattern(16'h0030);
      run_pattern(16'h000E);
      run_pattern(16'h0008);
      run_pattern(16'h00FF);
      run_pattern(16'h0003);
      exp_bin[1] = 10'd1;
      exp_bin[2] = 10'd2;
      exp_bin[3] = 10'd1;
      exp_bin[8] = 10'd1;
      read_all("seq");

      // 20-cycle run saturates into the last bin
      data_valid = 1'b1;
      repeat (20) step();
      data_valid = 1'b0;
      step();
      exp_bin[15] = 10'd1;
      read_bin("long", 15);
      read_bin("long", 4);

      // hist_int on the third valid cycle splits the run into 2 + 1
      data_valid = 1'b1;
      step();
      step();
      hist_int = 1'b1;
      step();
      hist_int = 1'b0;
      data_valid = 1'b0;
      step();
      exp_bin[2] = 10'd3;
      exp_bin[1] = 10'd2;
      read_all("split");

      // reset mid-run: the run must not commit after release
      data_valid = 1'b1;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      data_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();
      for (int i = 0; i < 16; i++) exp_bin[i] = '0;
      read_all("rstrun");

      // length-1 runs up to and past the bin counter limit
      for (int r = 0; r < 1023; r++) begin
         data_valid = 1'b1;
         step();
         data_valid = 1'b0;
         step();
      end
      exp_bin[1] = 10'd1023;
      read_bin("ovf1023", 1);
      for (int r = 0; r < 2; r++) begin
         data_valid = 1'b1;
         step();
         data_valid = 1'b0;
         step();
      end
`ifdef HISTO_SATURATE_EN
      exp_bin[1] = 10'd1023;
`else
      exp_bin[1] = 10'd1;
`endif
      read_bin("ovf1025", 1);

      // read/update collision on bin 4
      addr = 4'd4;
      data_valid = 1'b1;
      repeat (4) step();
      data_valid = 1'b0;
      step();
      check_val("collide_old", hist_data, 10'd0);
      step();
      check_val("collide_new", hist_data, 10'd1);
      exp_bin[4] = 10'd1;
      read_all("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/histo_run_length.md
HISTO_RUN_LENGTH -- requirements
Module: histo

Interface
REQ-001 SHALL have parameter MAX_SEQ_SIZE, default 16, the maximum sequence run length tracked (number of bins).
REQ-002 SHALL have parameter HISTO_BIN_MAX, default 1024, the bin counter range; counter width is log2(HISTO_BIN_MAX) = 10.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; synchronous and active-low.
REQ-005 SHALL have port data_in, input, 1 bit, the payload bit; it is sampled but does not affect the histogram.
REQ-006 SHALL have port data_valid, input, 1 bit; high marks a cycle belonging to the current run.
REQ-007 SHALL have port hist_int, input, 1 bit, a single-cycle sequence-start marker.
REQ-008 SHALL have port addr, input, 4 bits (log2 MAX_SEQ_SIZE), the bin read address.
REQ-009 SHALL have port hist_data, output, 10 bits, the registered count of bin addr.

Function
REQ-010 SHALL hold MAX_SEQ_SIZE bin counters bin[0..15], each 10 bits; bin[k] counts completed runs of length k.
REQ-011 SHALL keep a 5-bit run counter: +1 per cycle with data_valid=1, saturating at MAX_SEQ_SIZE.
REQ-012 SHALL commit a run when data_valid was 1 in the previous cycle and is 0 now (falling edge); it SHALL NOT commit when data_valid stays 0 or when the run length is 0.
REQ-013 On commit, SHALL increment bin[min(len, MAX_SEQ_SIZE-1)] one cycle after the falling edge and clear the run counter in the same cycle; runs of 16 or more land in bin 15.
REQ-014 A hist_int cycle SHALL commit any in-progress nonzero run and restart the run counter at 0; when data_valid=1 in that same cycle, that cycle starts the new run (count 1).
REQ-015 hist_int SHALL NOT clear the bins; bins accumulate across sequences until reset.
REQ-016 Non-contiguous valid cycles within one sequence SHALL form separate runs (e.g. 1,1,0,1 -> bin2+1, bin1+1).
REQ-017 Read: hist_data SHALL equal bin[addr] as sampled at the previous rising edge (1-cycle latency), updated every cycle with no read strobe.
REQ-018 Simultaneous read and increment of the same bin SHALL return the pre-increment value; the new value is visible on the next cycle.
REQ-019 Bin overflow SHALL follow REQ-024.

Reset
REQ-020 While rst_n=0 at a clock edge, SHALL clear all bins, the run counter, the previous-data_valid register and hist_data to 0.
REQ-021 A run in progress when reset is asserted SHALL be discarded and not committed after release.
REQ-022 SHALL accept stimulus on the first clock edge with rst_n=1.

Configuration
REQ-023 Macro HISTO_SATURATE_EN SHALL select the bin overflow behaviour.
REQ-024 With HISTO_SATURATE_EN defined, a bin SHALL hold at 1023 on further increments; without it, a bin SHALL wrap 1023 -> 0.

Verification
REQ-025 Reset, then read addr 0..15 -> hist_data 0 for every bin.
REQ-026 Five sequences, each preceded by a hist_int pulse, with data_valid patterns 0000_1100, 0111_0000, 0001_0000, 1111_1111, 1100_0000 (LSB first, 16 cycles each); read addr 2,3,1,8 -> 2,1,1,1; all other bins 0.
REQ-027 data_valid held high for 20 cycles, then low -> bin15 = 1, no other bin changes.
REQ-028 data_valid=1 for 3 cycles with hist_int on the 3rd cycle, then low -> bin2 +1, bin1 +1.
REQ-029 1025 runs of length 1 -> bin1 = 1023 with HISTO_SATURATE_EN, 1 without.
REQ-030 addr=4 held while a length-4 run commits -> hist_data shows the old value on the commit cycle and old+1 on the next cycle.
